// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the instruction/data SRAM arbiter: bus widths,
// requester-ID encoding, the legal read-latency window and the tag record
// carried through the response pipeline.
package sram_arbiter_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = DATA_W / 8;
  localparam int STARVE_W = 3;

  // Legal SRAM read latency window, in cycles
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  // Requester identity carried with every issued access
  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  // One slot of the response pipeline
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  // True when a read latency lies inside the supported window
  function automatic logic latLegal(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

  // Drops an instruction tag when a flush is active; data tags always survive
  function automatic tag_t scrubTag(input tag_t tag, input logic killInst);
    tag_t result;
    result = tag;
    if (killInst && (tag.owner == OWNER_INST)) begin
      result.valid = 1'b0;
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the requester-side handshakes and the SRAM port.
// master : the CPU pipeline issuing instruction and data requests
// slave  : the arbiter itself
// mem    : the synchronous SRAM answering the arbiter
interface sram_arbiter_if;
  import sram_arbiter_pkg::*;

  // Pipeline control
  logic              flush;

  // Instruction-side channel
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  // Data-side channel
  logic              data_req;
  logic              data_wr;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  // Shared SRAM port
  logic              sram_en;
  logic [STRB_W-1:0] sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    output flush,
    output inst_req, inst_addr,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  flush,
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport mem (
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/sram_arbiter_resp_tag_pipe.sv
// Response tag pipeline: one {valid, owner} slot per issued cycle, shifted
// forward every clock so the tag leaves the last stage exactly when the SRAM
// read data for that access appears. A flush kills every instruction tag in
// flight, including the one leaving the pipe in the flush cycle itself.
module resp_tag_pipe
  import sram_arbiter_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  owner_e owner_in,
  input  logic   kill_inst,
  output logic   out_valid,
  output owner_e out_owner
);

  tag_t stage_q [LAT];
  tag_t stage_d [LAT];
  tag_t inTag;
  tag_t exitTag;

  // Next-state of every stage: load the new tag, shift the rest, scrub inst tags on flush
  always_comb begin
    inTag.valid = push;
    inTag.owner = owner_in;
    for (int i = 0; i < LAT; i++) begin
      stage_d[i] = '0;
    end
    stage_d[0] = scrubTag(inTag, kill_inst);
    for (int i = 1; i < LAT; i++) begin
      stage_d[i] = scrubTag(stage_q[i-1], kill_inst);
    end
  end

  // Stage registers; reset empties the pipe so no pre-reset response survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // The leaving tag is also subject to a same-cycle flush
  always_comb begin
    exitTag   = scrubTag(stage_q[LAT-1], kill_inst);
    out_valid = exitTag.valid;
    out_owner = exitTag.owner;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single fixed-latency SRAM. Data accesses
// normally win; an instruction fetch that has lost STARVE_MAX cycles in a row
// is forced through. Grants are combinational (same-cycle addr_ok), responses
// come back in issue order LAT cycles later, steered by the tag pipeline.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           reset,
  sram_arbiter_if.slave bus
);

  // Parameter sanity: the tag pipe and the 3-bit counter only cover these ranges
  if (!latLegal(LAT)) begin : gLatRangeBad
    $error("sram_arbiter: LAT must lie within 1..4");
  end
  if ((STARVE_MAX < 1) || (STARVE_MAX > ((1 << STARVE_W) - 1))) begin : gStarveRangeBad
    $error("sram_arbiter: STARVE_MAX must fit the starvation counter");
  end

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

  logic [STARVE_W-1:0] starveCnt_q;
  logic [STARVE_W-1:0] starveCnt_d;

  logic   instEligible;
  logic   dataGrant;
  logic   instGrant;
  logic   anyGrant;
  owner_e grantOwner;
  logic   respValid;
  owner_e respOwner;

  // Arbitration: flush hides the fetch, data wins unless the fetch is starved
  always_comb begin
    instEligible = bus.inst_req & ~bus.flush & ~reset;
    dataGrant    = bus.data_req & ~reset &
                   ~(instEligible & (starveCnt_q == STARVE_LIM));
    instGrant    = instEligible & ~dataGrant;
    anyGrant     = instGrant | dataGrant;
    grantOwner   = instGrant ? OWNER_INST : OWNER_DATA;
  end

  // Starvation count: grows while an eligible fetch keeps losing, else restarts
  always_comb begin
    starveCnt_d = '0;
    if (instEligible && !instGrant) begin
      if (starveCnt_q < STARVE_LIM) begin
        starveCnt_d = starveCnt_q + STARVE_ONE;
      end else begin
        starveCnt_d = starveCnt_q;
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end

  // SRAM command: address mux follows the winner, write data always from the data side
  always_comb begin
    bus.inst_addr_ok = instGrant;
    bus.data_addr_ok = dataGrant;
    bus.sram_en      = anyGrant;
    bus.sram_wen     = (dataGrant && bus.data_wr) ? bus.data_wstrb : '0;
    bus.sram_addr    = instGrant ? bus.inst_addr : bus.data_addr;
    bus.sram_wdata   = bus.data_wdata;
  end

  resp_tag_pipe #(
    .LAT(LAT)
  ) uTagPipe (
    .clk      (clk),
    .reset    (reset),
    .push     (anyGrant),
    .owner_in (grantOwner),
    .kill_inst(bus.flush),
    .out_valid(respValid),
    .out_owner(respOwner)
  );

  // Response steering: the leaving tag picks which requester sees data_ok
  always_comb begin
    bus.inst_data_ok = respValid && (respOwner == OWNER_INST);
    bus.data_data_ok = respValid && (respOwner == OWNER_DATA);
    bus.inst_rdata   = bus.sram_rdata;
    bus.data_rdata   = bus.sram_rdata;
  end

endmodule
